vx_dispatch_arb: RTL
====================

Name: VX_dispatch_arb

Overview:
Shares one execution unit instance (ALU/LSU/SFU/FPU block) between NUM_REQS dispatch requesters (issue slices). Round-robin arbitration with one registered output stage. Each request is tagged with its source index, and the unit's commit response is routed back to that source by tag. A credit counter bounds in-flight operations so the unit's internal buffering never overflows.

Parameters:
NUM_REQS, 4, number of dispatch requesters (ISSUE_WIDTH); must be ≥1
DATA_WIDTH, 64, dispatch payload width (bits)
RSP_WIDTH, 64, commit payload width (bits)
MAX_PENDING, 8, maximum outstanding operations in the unit; must be ≥1
TAG_WIDTH, `LOG2UP(NUM_REQS), source tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_REQS  per-requester dispatch valid
req_data  in  NUM_REQS*DATA_WIDTH  per-requester dispatch payload
req_ready  out  NUM_REQS  per-requester dispatch accept
unit_valid  out  1  request to shared unit
unit_data  out  DATA_WIDTH  payload to unit
unit_tag  out  TAG_WIDTH  source index of unit_data
unit_ready  in  1  unit accepts request
rsp_valid  in  1  unit commit valid
rsp_data  in  RSP_WIDTH  unit commit payload
rsp_tag  in  TAG_WIDTH  tag returned with commit
rsp_ready  out  1  commit accept to unit
commit_valid  out  NUM_REQS  per-requester commit valid
commit_data  out  RSP_WIDTH  commit payload (shared across requesters)
commit_ready  in  NUM_REQS  per-requester commit accept
pending_count  out  `CLOG2(MAX_PENDING+1)  current in-flight count

Behaviour:
- Single clock clk; reset synchronous, active-high. On reset: unit_valid=0, pending_count=0, RR pointer=0, all req_ready=0 during reset, commit_valid follows rsp_valid gating (rsp_ready=0 during reset).
- Output stage: register {unit_valid, unit_data, unit_tag}. Stage "can load" when !unit_valid || unit_ready.
- Grant: among valid requesters, choose the first index at or after the RR pointer (wrapping modulo NUM_REQS). A grant occurs only when can_load && pending_count < MAX_PENDING && !reset. req_ready[i]=1 only for the granted i (one-hot or zero). On grant fire, the pointer becomes grant+1 mod NUM_REQS; otherwise it holds.
- Latency: a request accepted in cycle t appears on unit_valid in cycle t+1. Full throughput is 1/cycle while credits are available.
- Unit handshake: unit_data and unit_tag stay stable while unit_valid && !unit_ready.
- Credits: pending increments on grant fire and decrements on rsp_valid && rsp_ready. If both occur in the same cycle, the count is unchanged. When pending==MAX_PENDING, there is no grant, even if a response fires in the same cycle (the decrement is not used combinationally). pending never underflows; an assertion checks rsp fire with pending==0.
- Response routing is combinational: commit_valid[i] = rsp_valid && (rsp_tag==i); rsp_ready = commit_ready[rsp_tag]; commit_data = rsp_data. An assertion checks rsp_tag < NUM_REQS.
- NUM_REQS==1: no arbitration; pointer is a constant 0 and the tag is a constant 0.
- Reset mid-operation: the registered output is dropped and the credit count is cleared. The unit is reset by the same relay.

Optional Feature:
VX_DISPATCH_ARB_PERF_EN
- Defined: adds output perf_stalls (PERF_CTR_BITS), a 64-bit saturating-free wrapping counter. It increments each cycle any req_valid is high and no grant fires; reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package VX_gpu_pkg: dispatch/commit payload typedefs (sized by DATA_WIDTH/RSP_WIDTH) and the PERF_CTR_BITS constant.
- Sub-module VX_rr_arbiter (NUM_REQS, combinational grant plus registered pointer, with grant_valid/grant_index/grant_onehot and an enable input) is reused by other unit arbiters.

Test Plan:
- All 4 requesters valid continuously, unit_ready=1, MAX_PENDING=8, immediate responses → unit_tag sequence 0,1,2,3,0,… one per cycle; each commit_valid pulses for its own tag.
- req_valid=4'b0101, unit_ready=0 for 3 cycles → unit_valid held, unit_data/unit_tag=0 stable, req_ready all 0; after release, tag 2 is issued next.
- MAX_PENDING=2, no responses → exactly 2 grants, pending_count=2, req_ready stays 0; one rsp fire → pending 1, the next cycle grants.
- pending=2 (full) with a grant blocked and a response fire in the same cycle → pending=1, no grant that cycle; grant occurs in the following cycle.
- rsp_tag=3, commit_ready[3]=0 for 2 cycles → rsp_ready=0, pending unchanged; commit_ready[3]=1 → fire, pending decrements by 1.
- Reset asserted with unit_valid=1 and pending=5 → next cycle unit_valid=0, pending_count=0, pointer=0; with PERF_EN, perf_stalls=0.

Source files
------------

// File: rtl/vx_dispatch_arb_pkg.sv
// Shared GPU dispatch package: default payload types, perf counter width and
// the tag-width helper used by the dispatch arbiter and its sub-modules.
package vx_dispatch_arb_pkg;

  localparam int PERF_CTR_BITS = 64;

  typedef logic [63:0] dispatch_data_t;
  typedef logic [63:0] commit_data_t;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_dispatch_arb_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at a registered pointer;
// the pointer moves past the winner only when a grant is issued.
module vx_dispatch_arb_rr_arbiter #(
  parameter int NUM_REQS  = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  requests,
  input  logic                 enable,
  output logic                 grant_valid,
  output logic [IDX_WIDTH-1:0] grant_index,
  output logic [NUM_REQS-1:0]  grant_onehot
);

  generate
    if (NUM_REQS == 1) begin : g_single
      assign grant_valid  = enable && requests[0];
      assign grant_index  = '0;
      assign grant_onehot = grant_valid;
    end else begin : g_multi
      logic [IDX_WIDTH-1:0] ptr_reg;
      logic [IDX_WIDTH-1:0] ptr_next;
      logic [IDX_WIDTH-1:0] sel_index;
      logic                 found;

      always_comb begin
        found     = 1'b0;
        sel_index = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
          int                   sum;
          logic [IDX_WIDTH-1:0] idx;
          sum = int'(ptr_reg) + k;
          if (sum >= NUM_REQS) sum = sum - NUM_REQS;
          idx = IDX_WIDTH'(sum);
          if (!found && requests[idx]) begin
            found     = 1'b1;
            sel_index = idx;
          end
        end
      end

      assign grant_valid = enable && found;
      assign grant_index = sel_index;
      assign ptr_next    = (sel_index == IDX_WIDTH'(NUM_REQS - 1)) ? '0
                                                                   : sel_index + IDX_WIDTH'(1);

      for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_onehot
        assign grant_onehot[gi] = grant_valid && (sel_index == IDX_WIDTH'(gi));
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ptr_reg <= '0;
        end else if (grant_valid) begin
          ptr_reg <= ptr_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/vx_dispatch_arb.sv
// Shares one execution unit between NUM_REQS issue slices with round-robin
// dispatch, tag-routed commits and credit-bounded occupancy.
// Optional stall counter output enabled by VX_DISPATCH_ARB_PERF_EN.
module vx_dispatch_arb
  import vx_dispatch_arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int DATA_WIDTH  = $bits(dispatch_data_t),
  parameter int RSP_WIDTH   = $bits(commit_data_t),
  parameter int MAX_PENDING = 8,
  parameter int TAG_WIDTH   = log2up(NUM_REQS),
  localparam int PCW        = $clog2(MAX_PENDING + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           unit_valid,
  output logic [DATA_WIDTH-1:0]          unit_data,
  output logic [TAG_WIDTH-1:0]           unit_tag,
  input  logic                           unit_ready,
  input  logic                           rsp_valid,
  input  logic [RSP_WIDTH-1:0]           rsp_data,
  input  logic [TAG_WIDTH-1:0]           rsp_tag,
  output logic                           rsp_ready,
  output logic [NUM_REQS-1:0]            commit_valid,
  output logic [RSP_WIDTH-1:0]           commit_data,
  input  logic [NUM_REQS-1:0]            commit_ready,
  output logic [PCW-1:0]                 pending_count
`ifdef VX_DISPATCH_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]       perf_stalls
`endif
);

  logic                  unit_valid_reg;
  logic [DATA_WIDTH-1:0] unit_data_reg;
  logic [TAG_WIDTH-1:0]  unit_tag_reg;
  logic [PCW-1:0]        pending_reg;
  logic [PCW-1:0]        pending_next;

  logic                  can_load;
  logic                  grant_en;
  logic                  grant_valid;
  logic [TAG_WIDTH-1:0]  grant_index;
  logic [NUM_REQS-1:0]   grant_onehot;
  logic                  rsp_fire;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQS];

  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
      assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign commit_valid[gi] = rsp_valid && (rsp_tag == TAG_WIDTH'(gi));
    end
  endgenerate

  // The credit check uses the registered count only, so a response landing
  // in the same cycle cannot unblock a grant.
  assign can_load = !unit_valid_reg || unit_ready;
  assign grant_en = can_load && (pending_reg < PCW'(MAX_PENDING)) && !reset;

  vx_dispatch_arb_rr_arbiter #(
    .NUM_REQS  (NUM_REQS),
    .IDX_WIDTH (TAG_WIDTH)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (req_valid),
    .enable       (grant_en),
    .grant_valid  (grant_valid),
    .grant_index  (grant_index),
    .grant_onehot (grant_onehot)
  );

  assign req_ready = grant_onehot;

  always_comb begin
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (int'(rsp_tag) == i) rsp_ready = commit_ready[i];
    end
    if (reset) rsp_ready = 1'b0;
  end

  assign rsp_fire    = rsp_valid && rsp_ready;
  assign commit_data = rsp_data;

  always_comb begin
    pending_next = pending_reg;
    if (grant_valid && !rsp_fire) begin
      pending_next = pending_reg + PCW'(1);
    end else if (!grant_valid && rsp_fire && (pending_reg != '0)) begin
      pending_next = pending_reg - PCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unit_valid_reg <= 1'b0;
      unit_data_reg  <= '0;
      unit_tag_reg   <= '0;
      pending_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (can_load) begin
        unit_valid_reg <= grant_valid;
        if (grant_valid) begin
          unit_data_reg <= req_data_arr[grant_index];
          unit_tag_reg  <= grant_index;
        end
      end
    end
  end

  assign unit_valid    = unit_valid_reg;
  assign unit_data     = unit_data_reg;
  assign unit_tag      = unit_tag_reg;
  assign pending_count = pending_reg;

`ifdef VX_DISPATCH_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_stalls_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls_reg <= '0;
    end else if ((|req_valid) && !grant_valid) begin
      perf_stalls_reg <= perf_stalls_reg + PERF_CTR_BITS'(1);
    end
  end

  assign perf_stalls = perf_stalls_reg;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_fire && (pending_reg == '0)));
      assert (int'(rsp_tag) < NUM_REQS);
    end
  end

endmodule
